// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: frame FSM states,
// scan-code prefixes, event word layout and the PS/2 odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Event word: {ext, brk, code[7:0]}
    localparam int EV_W      = 10;
    localparam int EV_EXT    = 9;
    localparam int EV_BRK    = 8;
    localparam int EV_CODE_W = 8;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO; a write on a full FIFO is only
// taken when a read frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk_50,
    input  logic                     areset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign count   = cnt;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_50) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (!areset && do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_rx_stream.sv
// PS/2 device receiver: synchronised, filtered clock-edge strobe, 11-bit frame FSM
// with watchdog, error pulses, E0/F0 prefix folding and an event FIFO.
module ps2_rx_stream
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int FILTER_LEN    = 5,
    parameter int TIMEOUT_US    = 2000,
    parameter int FIFO_DEPTH    = 8,
    parameter int DECODE_PREFIX = 1
) (
    input  logic                          clk_50,
    input  logic                          areset,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [9:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout,
    output logic                          overflow,
    input  logic                          clr_ovf
);
    localparam int   TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int   WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic DECODE_EN   = (DECODE_PREFIX != 0);

    logic clk_s1, clk_s2, dat_s1, dat_s2;
    logic [2*FILTER_LEN-1:0] hist;
    logic strobe;

    ps2_state_e state, state_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shreg, shreg_n;
    logic            par_bit, par_n;
    logic [WD_W-1:0] wd_cnt, wd_n;
    logic acc, frm_err_c, par_err_c, to_err_c;

    logic ext, brk, is_prefix, push, pop, fifo_full, fifo_empty;
    logic [EV_W-1:0] push_data;

    always_ff @(posedge clk_50) begin
        if (areset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            hist   <= '1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
            hist   <= {clk_s2, hist[2*FILTER_LEN-1:1]};
        end
    end

    // Newest samples sit at the MSB end: a clean high run followed by a clean low run.
    assign strobe = (&hist[FILTER_LEN-1:0]) & ~(|hist[2*FILTER_LEN-1:FILTER_LEN]);

    always_ff @(posedge clk_50) begin
        if (areset) begin
            state   <= ST_IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            par_bit <= par_n;
            wd_cnt  <= wd_n;
        end
    end

    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_n     = par_bit;
        acc       = 1'b0;
        frm_err_c = 1'b0;
        par_err_c = 1'b0;
        to_err_c  = 1'b0;
        wd_n      = (strobe || state == ST_IDLE) ? '0 : wd_cnt + WD_W'(1);
        case (state)
            ST_IDLE: begin
                if (strobe && !dat_s2) begin
                    state_n  = ST_DATA;
                    bitcnt_n = '0;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    shreg_n  = {dat_s2, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (strobe) begin
                    par_n   = dat_s2;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe) begin
                    state_n = ST_IDLE;
                    if (!dat_s2)                          frm_err_c = 1'b1;
                    else if (par_bit != odd_parity(shreg)) par_err_c = 1'b1;
                    else                                   acc       = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // A strobe in the same cycle restarts the gap, so it never counts as a timeout.
        if (state != ST_IDLE && !strobe && wd_cnt >= WD_W'(TIMEOUT_CYC)) begin
            state_n  = ST_IDLE;
            to_err_c = 1'b1;
        end
    end

    assign is_prefix = DECODE_EN && (shreg == PS2_PFX_EXT || shreg == PS2_PFX_BRK);
    assign push      = acc && !is_prefix;
    assign pop       = rd_valid & rd_ready;

    always_comb begin
        push_data                  = '0;
        push_data[EV_CODE_W-1:0]   = shreg;
        push_data[EV_BRK]          = brk;
        push_data[EV_EXT]          = ext;
    end

    always_ff @(posedge clk_50) begin
        if (areset) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            err_parity  <= par_err_c;
            err_frame   <= frm_err_c;
            err_timeout <= to_err_c;
            if (frm_err_c || par_err_c || to_err_c) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (acc) begin
                if (is_prefix && shreg == PS2_PFX_EXT)      ext <= 1'b1;
                else if (is_prefix && shreg == PS2_PFX_BRK) brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
            // A new drop outranks a same-cycle clear.
            overflow <= (push & fifo_full & ~pop) | (overflow & ~clr_ovf);
        end
    end

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50  (clk_50),
        .areset  (areset),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (rd_ready),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_rx_stream.sv
// Scenario bench for ps2_rx_stream: drives PS/2 frames at a 40-cycle bit period
// and checks popped events against an expected-event queue.
module tb_ps2_rx_stream;
    import ps2_pkg::*;

    logic       clk_50 = 1'b0;
    logic       areset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       rd_valid;
    logic [9:0] rd_data;
    logic [2:0] fifo_count;
    logic       err_parity, err_frame, err_timeout, overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_par = 0, n_frm = 0, n_to = 0;
    int to_cyc = 0;
    int last_fall = 0;
    logic [9:0] exp_q[$];

    ps2_rx_stream #(
        .CLK_HZ        (1_000_000),
        .FILTER_LEN    (5),
        .TIMEOUT_US    (200),
        .FIFO_DEPTH    (4),
        .DECODE_PREFIX (1)
    ) dut (
        .clk_50      (clk_50),
        .areset      (areset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fifo_count  (fifo_count),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    // clock / reset / monitors
    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    always @(negedge clk_50) begin
        if (err_parity) n_par <= n_par + 1;
        if (err_frame)  n_frm <= n_frm + 1;
        if (err_timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
    end

    initial begin
        #600_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit expired");
    end

    // driver tasks
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            repeat (20) @(negedge clk_50);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            repeat (20) @(negedge clk_50);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk_50);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1, 11);
    endtask

    task automatic drain(input string name);
        logic [9:0] e;
        int budget = 50;
        rd_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (rd_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL %s_data: rd_data=%h expected %h", name, rd_data, e);
                end
            end
            @(negedge clk_50);
            budget--;
        end
        rd_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d events never appeared, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_extra: rd_valid=%b expected 0 after drain", name, rd_valid);
        end
    endtask

    // scenarios
    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk_50);
        checks++;
        if ({rd_valid, rd_data, fifo_count, err_parity, err_frame, err_timeout, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h count=%0d perr=%b ferr=%b terr=%b ovf=%b expected all 0",
                     rd_valid, rd_data, fifo_count, err_parity, err_frame, err_timeout, overflow);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: state=%0d expected %0d", dut.state, ST_IDLE);
        end
        areset = 1'b0;
        repeat (10) @(negedge clk_50);
    endtask

    task automatic test_glitch_and_basic();
        int bad = 0;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk_50);
        ps2_clk = 1'b1;
        repeat (20) begin
            @(negedge clk_50);
            if (dut.state !== ST_IDLE) bad++;
        end
        ps2_dat = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_state: left IDLE for %0d cycles, expected 0", bad);
        end
        repeat (10) @(negedge clk_50);
        exp_q.push_back(10'h01C);
        send_good(8'h1C);
        checks++;
        if (rd_valid !== 1'b1 || fifo_count !== 3'd1 || rd_data !== exp_q[0]) begin
            errors++;
            $display("FAIL basic_head: valid=%b count=%0d data=%h expected 1/1/%h",
                     rd_valid, fifo_count, rd_data, exp_q[0]);
        end
        drain("basic");
    endtask

    task automatic test_prefix();
        exp_q.push_back(10'h375);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL prefix_count: count=%0d expected 1", fifo_count);
        end
        drain("prefix");
    endtask

    task automatic test_parity();
        int p0 = n_par;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        checks++;
        if (n_par - p0 != 1) begin
            errors++;
            $display("FAIL parity_pulse: %0d pulse cycles, expected 1", n_par - p0);
        end
        checks++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_nopush: count=%0d valid=%b expected 0/0", fifo_count, rd_valid);
        end
    endtask

    task automatic test_frame_err();
        int f0 = n_frm;
        int p0 = n_par;
        send_good(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        checks++;
        if (n_frm - f0 != 1 || n_par - p0 != 0) begin
            errors++;
            $display("FAIL frame_pulse: frame=%0d parity=%0d expected 1/0", n_frm - f0, n_par - p0);
        end
        exp_q.push_back(10'h01C);
        send_good(8'h1C);
        drain("frame_next");
    endtask

    task automatic test_timeout();
        int t0 = n_to;
        int budget = 400;
        send_frame(8'h29, 1'b0, 1'b1, 5);
        while (n_to == t0 && budget > 0) begin
            @(negedge clk_50);
            budget--;
        end
        repeat (5) @(negedge clk_50);
        checks++;
        if (n_to - t0 != 1) begin
            errors++;
            $display("FAIL timeout_pulse: %0d pulse cycles, expected 1", n_to - t0);
        end
        checks++;
        if (to_cyc - last_fall < 200 || to_cyc - last_fall > 220) begin
            errors++;
            $display("FAIL timeout_delay: %0d cycles after last edge, expected 200..220", to_cyc - last_fall);
        end
        checks++;
        if (dut.state !== ST_IDLE || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL timeout_idle: state=%0d count=%0d expected IDLE/0", dut.state, fifo_count);
        end
        exp_q.push_back(10'h029);
        send_good(8'h29);
        drain("timeout_next");
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({2'b00, codes[i]});
            send_good(codes[i]);
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: count=%0d ovf=%b expected 4/1", fifo_count, overflow);
        end
        drain("overflow");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b expected 1", overflow);
        end
        clr_ovf = 1'b1;
        @(negedge clk_50);
        clr_ovf = 1'b0;
        @(negedge clk_50);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_reset_midframe();
        send_good(8'h16);
        send_frame(8'h45, 1'b0, 1'b1, 4);
        areset = 1'b1;
        @(negedge clk_50);
        checks++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0 || dut.state !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset: count=%0d valid=%b state=%0d expected 0/0/IDLE",
                     fifo_count, rd_valid, dut.state);
        end
        areset = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk_50);
        exp_q.push_back(10'h01C);
        send_good(8'h1C);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_glitch_and_basic();
        test_prefix();
        test_parity();
        test_frame_err();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
